// File: rtl/scrambler_pkg.sv
// Shared constants, payload types and the single-step LFSR helper for the 802.11a scrambler.
package scrambler_pkg;

    localparam int unsigned SCRAMBLER_LEN    = 7;
    localparam int unsigned SCRAMBLER_TAP_HI = 7;
    localparam int unsigned SCRAMBLER_TAP_LO = 4;
    localparam int unsigned RATE_W           = 4;

    localparam logic [SCRAMBLER_LEN-1:0] DEFAULT_SEED = 7'h5D;

    localparam logic [RATE_W-1:0] RATE_6M  = 4'hD;
    localparam logic [RATE_W-1:0] RATE_9M  = 4'hF;
    localparam logic [RATE_W-1:0] RATE_12M = 4'h5;
    localparam logic [RATE_W-1:0] RATE_18M = 4'h7;
    localparam logic [RATE_W-1:0] RATE_24M = 4'h9;
    localparam logic [RATE_W-1:0] RATE_36M = 4'hB;
    localparam logic [RATE_W-1:0] RATE_48M = 4'h1;
    localparam logic [RATE_W-1:0] RATE_54M = 4'h3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scr_state_e;

    typedef struct packed {
        logic [RATE_W-1:0] user;
        logic              last;
    } axis_side_t;

    // One scrambler step: returns {mask_bit, next_state}; state is {x7..x1}.
    function automatic logic [SCRAMBLER_LEN:0] lfsr_step(input logic [SCRAMBLER_LEN-1:0] s);
        logic x;
        x = s[SCRAMBLER_TAP_HI-1] ^ s[SCRAMBLER_TAP_LO-1];
        return {x, s[SCRAMBLER_LEN-2:0], x};
    endfunction

endpackage

// File: rtl/scrambler_axis_skid_buffer.sv
// Two-slot AXI-stream skid buffer with registered outputs and a registered s_tready.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_d;
    logic             push, pop;

    assign push = s_tvalid & s_tready;
    assign pop  = m_tvalid & m_tready;

    // Output slot refills from the skid slot first; s_tready is low only when both slots hold data.
    always_comb begin
        out_data_d   = m_tdata;
        out_valid_d  = m_tvalid;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (pop) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (push) begin
                out_data_d = s_tdata;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!m_tvalid) begin
                out_data_d  = s_tdata;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d  = s_tdata;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tdata      <= '0;
            m_tvalid     <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            s_tready     <= 1'b0;
        end else begin
            m_tdata      <= out_data_d;
            m_tvalid     <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            s_tready     <= ~skid_valid_d;
        end
    end

endmodule

// File: rtl/scrambler.sv
// IEEE 802.11a data scrambler (x^7+x^4+1), WIDTH bits per beat, with per-frame bypass.
module scrambler
    import scrambler_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [SCRAMBLER_LEN-1:0] seed,
    input  logic                     bypass,
    input  logic [WIDTH-1:0]         s_axis_tdata,
    input  logic [RATE_W-1:0]        s_axis_tuser,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    output logic [WIDTH-1:0]         m_axis_tdata,
    output logic [RATE_W-1:0]        m_axis_tuser,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast
);

    localparam int unsigned PAYLOAD_W = WIDTH + $bits(axis_side_t);

    scr_state_e               state_q, state_d;
    logic [SCRAMBLER_LEN-1:0] lfsr_q, lfsr_d;
    logic                     bypass_q, bypass_d;
    logic                     accept;
    logic                     frame_start;
    logic                     bypass_cur;
    logic [SCRAMBLER_LEN-1:0] lfsr_src, lfsr_adv;
    logic [SCRAMBLER_LEN:0]   step;
    logic [WIDTH-1:0]         mask;
    logic [WIDTH-1:0]         scr_data;
    axis_side_t               side_in, side_out;
    logic [PAYLOAD_W-1:0]     skid_in, skid_out;

    assign accept      = s_axis_tvalid & s_axis_tready;
    assign frame_start = (state_q == ST_IDLE);
    assign lfsr_src    = frame_start ? seed : lfsr_q;
    assign bypass_cur  = frame_start ? bypass : bypass_q;

    // Unroll WIDTH LFSR steps; bit k uses the state after k steps.
    always_comb begin
        lfsr_adv = lfsr_src;
        step     = '0;
        mask     = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            step     = lfsr_step(lfsr_adv);
            mask[k]  = step[SCRAMBLER_LEN];
            lfsr_adv = step[SCRAMBLER_LEN-1:0];
        end
    end

    assign scr_data = bypass_cur ? s_axis_tdata : (s_axis_tdata ^ mask);

    // Frame tracking; bypass and LFSR advance only on accepted beats.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        bypass_d = bypass_q;
        if (accept) begin
            state_d = s_axis_tlast ? ST_IDLE : ST_RUN;
            if (frame_start) begin
                bypass_d = bypass;
            end
            lfsr_d = bypass_cur ? lfsr_src : lfsr_adv;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= '0;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            bypass_q <= bypass_d;
        end
    end

    assign side_in.user = s_axis_tuser;
    assign side_in.last = s_axis_tlast;
    assign skid_in      = {scr_data, side_in};

    axis_skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (skid_in),
        .s_tvalid (s_axis_tvalid),
        .s_tready (s_axis_tready),
        .m_tdata  (skid_out),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready)
    );

    assign {m_axis_tdata, side_out} = skid_out;
    assign m_axis_tuser = side_out.user;
    assign m_axis_tlast = side_out.last;

endmodule

// File: tb/tb_scrambler.sv
// Self-checking bench for scrambler: directed frames plus random traffic against a sequence-table model.
module tb_scrambler;
    import scrambler_pkg::*;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned PW    = WIDTH + RATE_W + 1;

    logic             aclk;
    logic             aresetn;
    logic [6:0]       seed;
    logic             bypass;
    logic [WIDTH-1:0] s_axis_tdata;
    logic [3:0]       s_axis_tuser;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic [WIDTH-1:0] m_axis_tdata;
    logic [3:0]       m_axis_tuser;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;

    scrambler #(.WIDTH(WIDTH)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .seed          (seed),
        .bypass        (bypass),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int unsigned      tests_run;
    int unsigned      tests_failed;
    logic [PW-1:0]    exp_q[$];
    logic             seq_tab[127];
    int unsigned      bit_idx;
    logic             in_frame;
    logic             frame_byp;
    int unsigned      ready_pct;
    logic             acc_in;
    logic             prev_stall;
    logic [PW-1:0]    prev_out;
    logic [PW-1:0]    last_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 127-bit sequence from the recurrence b[n] = b[n-7] ^ b[n-4], history seeded with {x7..x1}.
    task automatic build_seq(input logic [6:0] sd);
        logic h[134];
        for (int i = 0; i < 7; i++) h[i] = sd[6-i];
        for (int n = 0; n < 127; n++) begin
            h[n+7]     = h[n] ^ h[n+3];
            seq_tab[n] = h[n+7];
        end
    endtask

    task automatic model_accept();
        logic [WIDTH-1:0] d;
        if (!in_frame) begin
            build_seq(seed);
            bit_idx   = 0;
            frame_byp = bypass;
        end
        d = s_axis_tdata;
        if (!frame_byp) begin
            for (int k = 0; k < int'(WIDTH); k++) d[k] = d[k] ^ seq_tab[(bit_idx + k) % 127];
            bit_idx = (bit_idx + WIDTH) % 127;
        end
        exp_q.push_back({d, s_axis_tuser, s_axis_tlast});
        in_frame = !s_axis_tlast;
    endtask

    // One clock: sample both handshakes at the falling edge, then advance to just past the rising edge.
    task automatic run_cycle();
        logic [PW-1:0] pay;
        m_axis_tready = ($urandom_range(0, 99) < ready_pct);
        @(negedge aclk);
        pay    = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        acc_in = s_axis_tvalid && s_axis_tready;
        check("s_ready_rule", 32'(s_axis_tready), 32'(exp_q.size() < 2));
        if (prev_stall) begin
            check("stall_valid", 32'(m_axis_tvalid), 32'd1);
            check("stall_data", 32'(pay), 32'(prev_out));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 32'(pay), 32'hFFFF_FFFF);
            end else begin
                check("out_beat", 32'(pay), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            last_out = pay;
        end
        if (acc_in) model_accept();
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out   = pay;
        @(posedge aclk);
        #1;
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] d, input logic [3:0] u, input logic l,
                             input logic [6:0] sd, input logic byp);
        int guard;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        seed          = sd;
        bypass        = byp;
        s_axis_tvalid = 1'b1;
        guard = 0;
        do begin
            run_cycle();
            guard++;
        end while (!acc_in && guard < 200);
        if (!acc_in) check("accept_timeout", 32'd0, 32'd1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        s_axis_tvalid = 1'b0;
        ready_pct = 100;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            run_cycle();
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic release_reset();
        check("rst_outputs", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'd0);
        exp_q.delete();
        in_frame   = 1'b0;
        prev_stall = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("ready_after_rst", 32'(s_axis_tready), 32'd1);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        aresetn       = 1'b0;
        seed          = 7'h7F;
        bypass        = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        ready_pct     = 100;
        in_frame      = 1'b0;
        prev_stall    = 1'b0;
        prev_out      = '0;
        last_out      = '0;
        acc_in        = 1'b0;
        bit_idx       = 0;
        frame_byp     = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        release_reset();

        // Single-beat all-zero frame, seed all ones.
        send_beat(24'h000000, RATE_12M, 1'b1, 7'h7F, 1'b0);
        drain();
        check("t1_literal", 32'(last_out), 32'({24'h934F70, RATE_12M, 1'b1}));

        // Six zero beats: 127-bit sequence then wrap.
        for (int i = 0; i < 6; i++) send_beat(24'h000000, RATE_24M, (i == 5), 7'h7F, 1'b0);
        drain();

        // Bypass frame, then a scrambled frame from its own seed.
        send_beat(24'h000C8D, RATE_6M, 1'b1, 7'h22, 1'b1);
        drain();
        check("t3_bypass_lit", 32'(last_out), 32'({24'h000C8D, RATE_6M, 1'b1}));
        send_beat(24'h000C8D, RATE_36M, 1'b1, 7'h7F, 1'b0);
        drain();
        check("t3_after_byp", 32'(last_out), 32'({24'h000C8D ^ 24'h934F70, RATE_36M, 1'b1}));

        // Back-to-back three-beat frames with different seeds.
        for (int i = 0; i < 3; i++) send_beat(WIDTH'($urandom), RATE_48M, (i == 2), 7'h7F, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(WIDTH'($urandom), RATE_54M, (i == 2), DEFAULT_SEED, 1'b0);
        drain();

        // Random valid gaps and ~50% downstream ready.
        for (int i = 0; i < 200; i++) begin
            ready_pct = 50;
            if ($urandom_range(0, 3) == 0) run_cycle();
            send_beat(WIDTH'($urandom), 4'($urandom), (i == 199) || ($urandom_range(0, 7) == 0),
                      7'($urandom_range(1, 127)), ($urandom_range(0, 5) == 0));
        end
        drain();

        // Reset while stalled with both slots full.
        ready_pct = 0;
        send_beat(WIDTH'($urandom), RATE_9M, 1'b0, 7'h3C, 1'b0);
        send_beat(WIDTH'($urandom), RATE_9M, 1'b0, 7'h3C, 1'b0);
        run_cycle();
        check("t6_full_ready", 32'(s_axis_tready), 32'd0);
        #2;
        aresetn = 1'b0;
        #1;
        check("t6_valid_drop", 32'(m_axis_tvalid), 32'd0);
        release_reset();
        send_beat(24'h000000, RATE_12M, 1'b1, 7'h7F, 1'b0);
        drain();
        check("t6_t1_repeat", 32'(last_out), 32'({24'h934F70, RATE_12M, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
